// File: rtl/speed_meter.sv
// speed_meter: measures the rate of a pulse/toggle stream.
// Rising edges of pulse_in are counted over a fixed window of GATE_CYCLES clocks.
// At the end of each window the count is published together with a 2-bit speed
// class (00 stopped, 01 slow, 10 medium, 11 fast). The class only reaches `mode`
// after two consecutive windows agree on it.
//
// Ports:
//   clk_100mhz  - system clock
//   rst         - asynchronous active-low reset
//   en          - measurement enable (synchronous)
//   pulse_in    - measured signal, asynchronous to clk_100mhz
//   count       - rising edges seen in the last completed window (saturating)
//   count_valid - one-cycle strobe: count/overflow/mode were updated this cycle
//   overflow    - the last completed window saturated the edge counter
//   mode        - debounced speed class
module speed_meter #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned THR_MED     = 1000,
    parameter int unsigned THR_FAST    = 20000
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic [1:0]       mode
);

    localparam int unsigned GateW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    localparam logic [1:0] ClsStop = 2'b00;
    localparam logic [1:0] ClsSlow = 2'b01;
    localparam logic [1:0] ClsMed  = 2'b10;
    localparam logic [1:0] ClsFast = 2'b11;

    logic             sync1_q, sync2_q, hist_q;
    logic [GateW-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       pending_q, pending_d;

    logic             rise;
    logic             sat;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic [1:0]       cls;

    // Edge detect on the synchronised value; history and synchroniser both
    // reset to 0, so an input already high at release still yields one edge.
    assign rise = sync2_q & ~hist_q;

    always_comb begin
        // An edge arriving while the counter is full is lost and marks overflow.
        sat      = rise && (edge_cnt_q == CntMax);
        cnt_next = (rise && !sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        ovf_next = ovf_q | sat;

        if (ovf_next) begin
            cls = ClsFast;
        end else if (cnt_next == '0) begin
            cls = ClsStop;
        end else if (32'(cnt_next) < THR_MED) begin
            cls = ClsSlow;
        end else if (32'(cnt_next) < THR_FAST) begin
            cls = ClsMed;
        end else begin
            cls = ClsFast;
        end
    end

    always_comb begin
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        pending_d  = pending_q;

        if (!en) begin
            // Disabled: discard any partial window, published results hold.
            gate_d     = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (gate_q == GateLast) begin
            // Terminal cycle: an edge here belongs to the closing window.
            gate_d     = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
            count_d    = cnt_next;
            overflow_d = ovf_next;
            valid_d    = 1'b1;
            if (cls == pending_q) begin
                mode_d = cls;
            end
            pending_d  = cls;
        end else begin
            gate_d     = gate_q + 1'b1;
            edge_cnt_d = cnt_next;
            ovf_d      = ovf_next;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            mode_q     <= ClsStop;
            pending_q  <= ClsStop;
        end else begin
            sync1_q    <= pulse_in;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter. Three instances share the stimulus:
//   dut_m: CNT_W=8, THR_MED=10, THR_FAST=40
//   dut_f: CNT_W=8, THR_MED=10, THR_FAST=20
//   dut_o: CNT_W=4, THR_MED=10, THR_FAST=40
// Inputs are driven on the falling edge; k counts falling edges since reset
// release, and pulse_in during falling edge k is the pattern value f(k).
module tb_speed_meter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1;
    logic pulse_in = 1'b0;

    logic [7:0] count_m, count_f;
    logic [3:0] count_o;
    logic       valid_m, valid_f, valid_o;
    logic       ovf_m, ovf_f, ovf_o;
    logic [1:0] mode_m, mode_f, mode_o;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    int pat = 0;
    int per = 1;
    int at, r, strobes;

    always #5 clk = ~clk;

    speed_meter #(.GATE_CYCLES(100), .CNT_W(8), .THR_MED(10), .THR_FAST(40)) dut_m (
        .clk_100mhz(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .count(count_m), .count_valid(valid_m), .overflow(ovf_m), .mode(mode_m)
    );
    speed_meter #(.GATE_CYCLES(100), .CNT_W(8), .THR_MED(10), .THR_FAST(20)) dut_f (
        .clk_100mhz(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .count(count_f), .count_valid(valid_f), .overflow(ovf_f), .mode(mode_f)
    );
    speed_meter #(.GATE_CYCLES(100), .CNT_W(4), .THR_MED(10), .THR_FAST(40)) dut_o (
        .clk_100mhz(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .count(count_o), .count_valid(valid_o), .overflow(ovf_o), .mode(mode_o)
    );

    // 0: low, 1: high, 2: period `per` starting with the low half,
    // 3: one pulse rising at k=10, then high from k=97 (terminal-cycle edge).
    function automatic logic pat_val(input int kk);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (kk % per) >= (per / 2);
            default: return (kk >= 10 && kk <= 19) || kk >= 97;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
        pulse_in = pat_val(k);
    endtask

    // Returns the k at which dut_m's strobe is seen, or -1 after the budget.
    task automatic wait_strobe(output int found);
        found = -1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (valid_m) begin
                found = k;
                break;
            end
        end
    endtask

    task automatic do_reset(input int p, input int pe);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        pat = p;
        per = pe;
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_overflow", ovf_m, 0);
        chk("rst_mode", mode_m, 0);
        k = 0;
        pulse_in = pat_val(0);
        rst = 1'b1;
    endtask

    initial begin
        // Stopped: strobes every 100 cycles, nothing counted.
        do_reset(0, 1);
        wait_strobe(at);
        chk("stop_w1_time", at, 100);
        chk("stop_w1_count", count_m, 0);
        tick();
        chk("stop_strobe_width", valid_m, 0);
        wait_strobe(at);
        chk("stop_w2_time", at, 200);
        wait_strobe(at);
        chk("stop_w3_time", at, 300);
        chk("stop_w3_count", count_m, 0);
        chk("stop_w3_mode", mode_m, 0);
        chk("stop_w3_overflow", ovf_m, 0);

        // Slow: period 20 -> 5 edges per window, mode follows on window 2.
        do_reset(2, 20);
        wait_strobe(at);
        chk("slow_w1_count", count_m, 5);
        chk("slow_w1_mode", mode_m, 0);
        wait_strobe(at);
        chk("slow_w2_count", count_m, 5);
        chk("slow_w2_mode", mode_m, 1);

        // Period 4: rises at k=2..94 (24) in window 1, 25 per window afterwards.
        do_reset(2, 4);
        wait_strobe(at);
        chk("med_w1_count", count_m, 24);
        chk("med_w1_mode", mode_m, 0);
        chk("fast_w1_mode", mode_f, 0);
        chk("ovf_w1_count", count_o, 15);
        chk("ovf_w1_overflow", ovf_o, 1);
        chk("ovf_w1_mode", mode_o, 0);
        wait_strobe(at);
        chk("med_w2_count", count_m, 25);
        chk("med_w2_mode", mode_m, 2);
        chk("fast_w2_count", count_f, 25);
        chk("fast_w2_mode", mode_f, 3);
        chk("ovf_w2_count", count_o, 15);
        chk("ovf_w2_overflow", ovf_o, 1);
        chk("ovf_w2_mode", mode_o, 3);
        // Input goes quiet; only the rise at k=198 lands in window 3.
        pat = 0;
        wait_strobe(at);
        chk("quiet_w3_count", count_m, 1);
        chk("quiet_w3_mode_held", mode_m, 2);
        chk("ovf_w3_overflow", ovf_o, 0);
        chk("ovf_w3_mode_held", mode_o, 3);

        // Asynchronous reset mid-window with the input high.
        repeat (30) tick();
        pat = 1;
        pulse_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", count_m, 0);
        chk("async_rst_mode_m", mode_m, 0);
        chk("async_rst_mode_o", mode_o, 0);
        chk("async_rst_valid", valid_m, 0);

        // Steady high after release: exactly one edge.
        do_reset(1, 1);
        wait_strobe(at);
        chk("high_w1_count", count_m, 1);
        wait_strobe(at);
        chk("high_w2_count", count_m, 0);

        // Edge detected in the terminal cycle stays in the closing window.
        do_reset(3, 1);
        wait_strobe(at);
        chk("term_w1_count", count_m, 2);
        wait_strobe(at);
        chk("term_w2_count", count_m, 0);

        // Enable dropped for 50 cycles mid-window.
        do_reset(2, 20);
        repeat (30) tick();
        en = 1'b0;
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid_m) strobes++;
        end
        chk("en_off_no_strobe", strobes, 0);
        en = 1'b1;
        r = k;
        wait_strobe(at);
        chk("en_restart_time", at, r + 100);
        chk("en_restart_count", count_m, 5);
        chk("en_restart_mode", mode_m, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
